// File: rtl/alarm_clock_pkg.sv
// Shared types, BCD limits and the BCD increment helper for the alarm clock controller.
package alarm_clock_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SET_TIME  = 2'd1,
        SET_ALARM = 2'd2
    } state_e;

    localparam logic [7:0] HOUR_MAX   = 8'h23;
    localparam logic [7:0] MINSEC_MAX = 8'h59;

    // Increment a two-digit BCD value, wrapping to 00 after max.
    function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max);
        logic [7:0] r;
        if (val == max) begin
            r = 8'h00;
        end else if (val[3:0] == 4'd9) begin
            r = {val[7:4] + 4'd1, 4'd0};
        end else begin
            r = {val[7:4], val[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/alarm_clock_ctrl_button_conditioner.sv
// Raw active-low button -> 2-flop synchronizer -> debounce -> single-cycle press pulse.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_clk,
    input  logic reset_reset_n,
    input  logic btn_n,
    output logic press
);

    localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // level_q is the accepted (debounced) level; a press fires only on an accepted 1->0 change.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/alarm_clock_ctrl.sv
// Alarm clock sequencer: button conditioning, run/set-time/set-alarm FSM,
// BCD time and alarm registers, alarm ring timing and LED/7-segment outputs.
module alarm_clock_ctrl
    import alarm_clock_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 50000000,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned RING_SECONDS    = 60
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       set_mode_btn_n,
    input  logic       confirm_btn_n,
    input  logic       inc_hour_btn_n,
    input  logic       inc_min_btn_n,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [9:0] leds,
    output logic       ringing
);

    localparam int unsigned   PW        = $clog2(CLK_HZ);
    localparam int unsigned   RW        = $clog2(RING_SECONDS + 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRE_HALF  = PW'(CLK_HZ / 2);
    localparam logic [RW-1:0] RING_LOAD = RW'(RING_SECONDS);

    logic set_mode_p, confirm_p, inc_hour_p, inc_min_p;
    logic do_set, do_conf, do_inc_h, do_inc_m;
    logic tick, blink;

    state_e        state_q, state_d;
    logic [PW-1:0] pres_q, pres_d;
    logic [7:0]    hour_q, hour_d, min_q, min_d, sec_q, sec_d;
    logic [7:0]    alarm_h_q, alarm_h_d, alarm_m_q, alarm_m_d;
    logic [7:0]    edit_h_q, edit_h_d, edit_m_q, edit_m_d;
    logic          alarm_en_q, alarm_en_d;
    logic          ringing_q, ringing_d;
    logic [RW-1:0] ring_cnt_q, ring_cnt_d;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_set (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .btn_n(set_mode_btn_n), .press(set_mode_p));
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_conf (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .btn_n(confirm_btn_n), .press(confirm_p));
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_hour (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .btn_n(inc_hour_btn_n), .press(inc_hour_p));
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_min (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .btn_n(inc_min_btn_n), .press(inc_min_p));

    // set_mode beats confirm beats the increments; losers are dropped, both increments may apply.
    assign do_set   = set_mode_p;
    assign do_conf  = confirm_p & ~set_mode_p;
    assign do_inc_h = inc_hour_p & ~set_mode_p & ~confirm_p;
    assign do_inc_m = inc_min_p & ~set_mode_p & ~confirm_p;

    assign tick  = (pres_q == PRE_LAST);
    assign blink = (pres_q < PRE_HALF);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:       if (do_set) state_d = SET_TIME;
            SET_TIME:  if (do_set) state_d = SET_ALARM; else if (do_conf) state_d = RUN;
            SET_ALARM: if (do_set || do_conf) state_d = RUN;
            default:   state_d = RUN;
        endcase
    end

    always_comb begin
        pres_d     = tick ? '0 : pres_q + PW'(1);
        hour_d     = hour_q;
        min_d      = min_q;
        sec_d      = sec_q;
        alarm_h_d  = alarm_h_q;
        alarm_m_d  = alarm_m_q;
        alarm_en_d = alarm_en_q;
        edit_h_d   = edit_h_q;
        edit_m_d   = edit_m_q;
        ringing_d  = ringing_q;
        ring_cnt_d = ring_cnt_q;

        if (tick && state_q != SET_TIME) begin
            sec_d = bcd_inc(sec_q, MINSEC_MAX);
            if (sec_q == MINSEC_MAX) begin
                min_d = bcd_inc(min_q, MINSEC_MAX);
                if (min_q == MINSEC_MAX) hour_d = bcd_inc(hour_q, HOUR_MAX);
            end
        end

        if (ringing_q && tick) begin
            ring_cnt_d = ring_cnt_q - RW'(1);
            if (ring_cnt_q == RW'(1)) ringing_d = 1'b0;
        end

        // Match only on the tick that rolls the time onto hh:mm:00 of the alarm.
        if (tick && alarm_en_q && state_q != SET_TIME && sec_d == 8'h00 &&
            hour_d == alarm_h_q && min_d == alarm_m_q) begin
            ringing_d  = 1'b1;
            ring_cnt_d = RING_LOAD;
        end

        case (state_q)
            RUN: begin
                if (do_set) begin
                    edit_h_d   = hour_q;
                    edit_m_d   = min_q;
                    ringing_d  = 1'b0;
                    ring_cnt_d = '0;
                end else if (do_conf) begin
                    if (ringing_q) begin
                        ringing_d  = 1'b0;
                        ring_cnt_d = '0;
                    end else begin
                        alarm_en_d = ~alarm_en_q;
                        if (alarm_en_q) ringing_d = 1'b0;
                    end
                end
            end
            SET_TIME: begin
                if (do_set) begin
                    edit_h_d = alarm_h_q;
                    edit_m_d = alarm_m_q;
                end else if (do_conf) begin
                    hour_d = edit_h_q;
                    min_d  = edit_m_q;
                    sec_d  = 8'h00;
                    pres_d = '0;
                end else begin
                    if (do_inc_h) edit_h_d = bcd_inc(edit_h_q, HOUR_MAX);
                    if (do_inc_m) edit_m_d = bcd_inc(edit_m_q, MINSEC_MAX);
                end
            end
            SET_ALARM: begin
                if (do_conf) begin
                    alarm_h_d  = edit_h_q;
                    alarm_m_d  = edit_m_q;
                    alarm_en_d = 1'b1;
                end else if (!do_set) begin
                    if (do_inc_h) edit_h_d = bcd_inc(edit_h_q, HOUR_MAX);
                    if (do_inc_m) edit_m_d = bcd_inc(edit_m_q, MINSEC_MAX);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pres_q     <= '0;
            hour_q     <= 8'h00;
            min_q      <= 8'h00;
            sec_q      <= 8'h00;
            alarm_h_q  <= 8'h00;
            alarm_m_q  <= 8'h00;
            alarm_en_q <= 1'b0;
            edit_h_q   <= 8'h00;
            edit_m_q   <= 8'h00;
            ringing_q  <= 1'b0;
            ring_cnt_q <= '0;
        end else begin
            pres_q     <= pres_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            alarm_h_q  <= alarm_h_d;
            alarm_m_q  <= alarm_m_d;
            alarm_en_q <= alarm_en_d;
            edit_h_q   <= edit_h_d;
            edit_m_q   <= edit_m_d;
            ringing_q  <= ringing_d;
            ring_cnt_q <= ring_cnt_d;
        end
    end

    always_comb begin
        if (state_q == RUN) begin
            hour_bcd = hour_q;
            min_bcd  = min_q;
            sec_bcd  = sec_q;
        end else begin
            hour_bcd = edit_h_q;
            min_bcd  = edit_m_q;
            sec_bcd  = 8'h00;
        end
        if (ringing_q) begin
            leds = {10{blink}};
        end else begin
            leds = {7'd0, (state_q == SET_ALARM), (state_q == SET_TIME), alarm_en_q};
        end
    end

    assign ringing = ringing_q;

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Directed bench for alarm_clock_ctrl with CLK_HZ=4, DEBOUNCE_CYCLES=2, RING_SECONDS=3.
module tb_alarm_clock_ctrl;

    localparam logic [3:0] B_SET  = 4'b0001;
    localparam logic [3:0] B_CONF = 4'b0010;
    localparam logic [3:0] B_HOUR = 4'b0100;
    localparam logic [3:0] B_MIN  = 4'b1000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn_n;
    logic [7:0] hour_bcd, min_bcd, sec_bcd;
    logic [9:0] leds;
    logic       ringing;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alarm_clock_ctrl #(
        .CLK_HZ(4),
        .DEBOUNCE_CYCLES(2),
        .RING_SECONDS(3)
    ) dut (
        .clk_clk(clk),
        .reset_reset_n(rst_n),
        .set_mode_btn_n(btn_n[0]),
        .confirm_btn_n(btn_n[1]),
        .inc_hour_btn_n(btn_n[2]),
        .inc_min_btn_n(btn_n[3]),
        .hour_bcd(hour_bcd),
        .min_bcd(min_bcd),
        .sec_bcd(sec_bcd),
        .leds(leds),
        .ringing(ringing)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    // Press for 4 cycles; returns on the first negedge where the effect is visible.
    task automatic press_btn(input logic [3:0] mask);
        btn_n = ~mask;
        repeat (4) @(negedge clk);
        btn_n = 4'hF;
        @(negedge clk);
    endtask

    task automatic rearm();
        repeat (4) @(negedge clk);
    endtask

    task automatic tap(input logic [3:0] mask);
        press_btn(mask);
        rearm();
    endtask

    task automatic wait_disp(input string tag, input logic [7:0] h, input logic [7:0] m,
                             input logic [7:0] s, input int budget);
        int i;
        i = 0;
        while (i < budget && !(hour_bcd == h && min_bcd == m && sec_bcd == s)) begin
            @(negedge clk);
            i++;
        end
        check(tag, {31'd0, (hour_bcd == h && min_bcd == m && sec_bcd == s)}, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hour"}, hour_bcd, 8'h00);
        check({tag, "_min"}, min_bcd, 8'h00);
        check({tag, "_sec"}, sec_bcd, 8'h00);
        check({tag, "_leds"}, leds, 10'h000);
        check({tag, "_ring"}, ringing, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        btn_n = 4'hF;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Free run: one tick every 4 cycles
        repeat (3) @(negedge clk);
        check("sec_before_tick", sec_bcd, 8'h00);
        @(negedge clk);
        check("sec_step_1", sec_bcd, 8'h01);
        for (int i = 2; i < 60; i++) begin
            repeat (4) @(negedge clk);
            check("sec_step", sec_bcd, to_bcd(i));
        end
        repeat (4) @(negedge clk);
        check("min_carry", min_bcd, 8'h01);
        check("sec_wrap", sec_bcd, 8'h00);
        check("run_leds", leds, 10'h000);

        // Reset mid-run
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_run");
        @(negedge clk);
        rst_n = 1'b1;

        // Enter SET_TIME
        press_btn(B_SET);
        check("settime_leds", leds, 10'h002);
        check("settime_hour", hour_bcd, 8'h00);
        check("settime_min", min_bcd, 8'h00);
        rearm();

        // Glitch and long hold
        btn_n[3] = 1'b0;
        @(negedge clk);
        btn_n[3] = 1'b1;
        repeat (8) @(negedge clk);
        check("glitch_min", min_bcd, 8'h00);
        btn_n[3] = 1'b0;
        repeat (10) @(negedge clk);
        btn_n[3] = 1'b1;
        repeat (5) @(negedge clk);
        check("hold_min", min_bcd, 8'h01);

        for (int i = 0; i < 58; i++) tap(B_MIN);
        check("edit_min_59", min_bcd, 8'h59);
        tap(B_MIN);
        check("edit_min_wrap", min_bcd, 8'h00);
        check("edit_min_nocarry", hour_bcd, 8'h00);
        for (int i = 0; i < 59; i++) tap(B_MIN);
        for (int i = 0; i < 24; i++) tap(B_HOUR);
        check("edit_hour_wrap", hour_bcd, 8'h00);
        for (int i = 0; i < 23; i++) tap(B_HOUR);
        check("edit_hour_23", hour_bcd, 8'h23);
        check("edit_min_back", min_bcd, 8'h59);

        press_btn(B_CONF);
        check("confirm_hour", hour_bcd, 8'h23);
        check("confirm_min", min_bcd, 8'h59);
        check("confirm_sec", sec_bcd, 8'h00);
        check("confirm_leds", leds, 10'h000);
        repeat (59 * 4) @(negedge clk);
        check("t235959_sec", sec_bcd, 8'h59);
        check("t235959_min", min_bcd, 8'h59);
        repeat (4) @(negedge clk);
        check("midnight_hour", hour_bcd, 8'h00);
        check("midnight_min", min_bcd, 8'h00);
        check("midnight_sec", sec_bcd, 8'h00);

        // Set alarm to 00:01
        tap(B_SET);
        press_btn(B_SET);
        check("setalarm_leds", leds, 10'h004);
        check("setalarm_min", min_bcd, 8'h00);
        rearm();
        tap(B_MIN);
        press_btn(B_CONF);
        check("alarm_en_leds", leds, 10'h001);
        check("alarm_not_ringing", ringing, 1'b0);
        rearm();

        wait_disp("reach_0001", 8'h00, 8'h01, 8'h00, 400);
        check("ring_start", ringing, 1'b1);
        check("ring_leds_on", leds, 10'h3FF);
        repeat (2) @(negedge clk);
        check("ring_leds_off", leds, 10'h000);
        wait_disp("reach_000102", 8'h00, 8'h01, 8'h02, 20);
        check("ring_still", ringing, 1'b1);
        wait_disp("reach_000103", 8'h00, 8'h01, 8'h03, 20);
        check("ring_timeout", ringing, 1'b0);
        check("ring_timeout_leds", leds, 10'h001);

        // Alarm to 00:02, dismiss, then disable
        tap(B_SET);
        tap(B_SET);
        tap(B_MIN);
        tap(B_CONF);
        wait_disp("reach_0002", 8'h00, 8'h02, 8'h00, 400);
        check("ring2_start", ringing, 1'b1);
        press_btn(B_CONF);
        check("dismiss_ring", ringing, 1'b0);
        check("dismiss_keeps_en", leds, 10'h001);
        rearm();
        press_btn(B_CONF);
        check("disable_leds", leds, 10'h000);
        check("disable_ring", ringing, 1'b0);
        rearm();

        // Simultaneous set_mode + confirm in SET_TIME
        tap(B_SET);
        for (int i = 0; i < 3; i++) tap(B_HOUR);
        check("edit_hour_03", hour_bcd, 8'h03);
        press_btn(B_SET | B_CONF);
        check("simul_leds", leds, 10'h004);
        check("simul_alarm_hour", hour_bcd, 8'h00);
        check("simul_alarm_min", min_bcd, 8'h02);
        rearm();
        press_btn(B_SET);
        check("back_run_leds", leds, 10'h000);
        check("time_kept_hour", hour_bcd, 8'h00);
        check("time_kept_min", min_bcd, 8'h02);
        rearm();

        // Reset mid-edit with a button held
        tap(B_SET);
        tap(B_HOUR);
        check("midedit_hour", hour_bcd, 8'h01);
        btn_n[2] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_edit");
        @(negedge clk);
        btn_n[2] = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post_reset_leds", leds, 10'h000);
        check("post_reset_hour", hour_bcd, 8'h00);
        check("post_reset_min", min_bcd, 8'h00);
        check("post_reset_sec", sec_bcd, 8'h02);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
